// File: rtl/sub_bf16_pipe.sv
// Three-stage pipelined bfloat16 subtractor (a - b) with RNE rounding.
// Stages: unpack/align, add/sub + leading-zero count, normalize/round/pack.
module sub_bf16_pipe (
    input  logic        clk,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] diff_out,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // All stages move together on advance; a full, unconsumed output stalls everything.
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // ---------------- S1: unpack / align (combinational) ----------------
    logic        a_zero, b_zero, a_bigger, eff_sub, big_sign;
    logic [14:0] a_mag, b_mag, big_mag, small_mag;
    logic [10:0] big_sig, small_sig, shifted, lost, small_al;
    logic [7:0]  exp_diff;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        sp_hit, sp_inv;
    logic [15:0] sp_val;

    always_comb begin
        a_zero    = (a_in[14:7] == 8'd0);
        b_zero    = (b_in[14:7] == 8'd0);
        a_mag     = a_zero ? 15'd0 : a_in[14:0];
        b_mag     = b_zero ? 15'd0 : b_in[14:0];
        a_bigger  = (a_mag >= b_mag);
        big_mag   = a_bigger ? a_mag : b_mag;
        small_mag = a_bigger ? b_mag : a_mag;
        big_sign  = a_bigger ? a_in[15] : ~b_in[15];
        eff_sub   = (a_in[15] == b_in[15]);
        big_sig   = {(big_mag[14:7] != 8'd0), big_mag[6:0], 3'b000};
        small_sig = {(small_mag[14:7] != 8'd0), small_mag[6:0], 3'b000};
        exp_diff  = big_mag[14:7] - small_mag[14:7];
        shifted   = 11'd0;
        lost      = 11'd0;
        if (exp_diff >= 8'd11) begin
            small_al = {10'd0, |small_sig};
        end else begin
            shifted  = small_sig >> exp_diff[3:0];
            lost     = small_sig & ~(11'h7FF << exp_diff[3:0]);
            small_al = {shifted[10:1], shifted[0] | (|lost)};
        end

        a_nan  = (&a_in[14:7]) & (|a_in[6:0]);
        b_nan  = (&b_in[14:7]) & (|b_in[6:0]);
        a_inf  = (&a_in[14:7]) & ~(|a_in[6:0]);
        b_inf  = (&b_in[14:7]) & ~(|b_in[6:0]);
        sp_hit = 1'b1;
        sp_inv = 1'b0;
        sp_val = 16'h0000;
        if (a_nan || b_nan || (a_inf && b_inf && (a_in[15] == b_in[15]))) begin
            sp_val = 16'h7FC0;
            sp_inv = 1'b1;
        end else if (a_inf) begin
            sp_val = a_in;
        end else if (b_inf) begin
            sp_val = {~b_in[15], 8'hFF, 7'h00};
        end else if (a_zero && b_zero) begin
            sp_val = {a_in[15] & ~b_in[15], 15'h0000};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // ---------------- S2: add/sub + LZC (combinational) ----------------
    logic        s1_valid, s1_special, s1_spec_inv, s1_sign, s1_sub;
    logic [15:0] s1_spec_val;
    logic [7:0]  s1_exp;
    logic [10:0] s1_big, s1_small;
    logic [11:0] sum12;
    logic [3:0]  lzc;

    function automatic logic [3:0] lzc12(input logic [11:0] v);
        lzc12 = 4'd12;
        for (int i = 0; i < 12; i++)
            if (v[i]) lzc12 = 4'(11 - i);
    endfunction

    always_comb begin
        // Larger magnitude is always the minuend, so the difference never goes negative.
        sum12 = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                       : ({1'b0, s1_big} + {1'b0, s1_small});
        lzc   = lzc12(sum12);
    end

    // ---------------- S3: normalize / round / pack (combinational) ----------------
    logic        s2_valid, s2_special, s2_spec_inv, s2_sign;
    logic [15:0] s2_spec_val;
    logic [7:0]  s2_exp;
    logic [11:0] s2_sum;
    logic [3:0]  s2_lzc, shamt;
    logic [10:0] norm;
    logic [9:0]  exp_n, exp_r;
    logic [8:0]  rounded;
    logic [6:0]  frac_r;
    logic        round_up;
    logic [15:0] res_val;
    logic        res_ovf, res_unf, res_inv;

    always_comb begin
        shamt = s2_lzc - 4'd1;
        if (s2_sum[11]) begin
            norm  = {s2_sum[11:2], s2_sum[1] | s2_sum[0]};
            exp_n = {2'b00, s2_exp} + 10'd1;
        end else begin
            norm  = s2_sum[10:0] << shamt;
            exp_n = {2'b00, s2_exp} - {6'd0, shamt};
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded  = {1'b0, norm[10:3]} + {8'd0, round_up};
        exp_r    = exp_n + {9'd0, rounded[8]};
        frac_r   = rounded[8] ? 7'd0 : rounded[6:0];

        // exp_r is two's complement: bit 9 set means the exponent went below zero.
        res_val = {s2_sign, exp_r[7:0], frac_r};
        res_ovf = 1'b0;
        res_unf = 1'b0;
        res_inv = 1'b0;
        if (s2_special) begin
            res_val = s2_spec_val;
            res_inv = s2_spec_inv;
        end else if (s2_sum == 12'd0) begin
            res_val = 16'h0000;
        end else if (!exp_r[9] && (exp_r >= 10'd255)) begin
            res_val = {s2_sign, 8'hFF, 7'h00};
            res_ovf = 1'b1;
        end else if (exp_r[9] || (exp_r == 10'd0)) begin
            res_val = {s2_sign, 15'h0000};
            res_unf = 1'b1;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            s1_valid    <= 1'b0;
            s1_special  <= 1'b0;
            s1_spec_inv <= 1'b0;
            s1_spec_val <= 16'h0000;
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_exp      <= 8'd0;
            s1_big      <= 11'd0;
            s1_small    <= 11'd0;
            s2_valid    <= 1'b0;
            s2_special  <= 1'b0;
            s2_spec_inv <= 1'b0;
            s2_spec_val <= 16'h0000;
            s2_sign     <= 1'b0;
            s2_exp      <= 8'd0;
            s2_sum      <= 12'd0;
            s2_lzc      <= 4'd0;
            out_valid   <= 1'b0;
            diff_out    <= 16'h0000;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            invalid     <= 1'b0;
        end else if (advance) begin
            s1_valid    <= in_valid;
            s1_special  <= sp_hit;
            s1_spec_inv <= sp_inv;
            s1_spec_val <= sp_val;
            s1_sign     <= big_sign;
            s1_sub      <= eff_sub;
            s1_exp      <= big_mag[14:7];
            s1_big      <= big_sig;
            s1_small    <= small_al;
            s2_valid    <= s1_valid;
            s2_special  <= s1_special;
            s2_spec_inv <= s1_spec_inv;
            s2_spec_val <= s1_spec_val;
            s2_sign     <= s1_sign;
            s2_exp      <= s1_exp;
            s2_sum      <= sum12;
            s2_lzc      <= lzc;
            out_valid   <= s2_valid;
            diff_out    <= res_val;
            overflow    <= res_ovf;
            underflow   <= res_unf;
            invalid     <= res_inv;
        end
    end

endmodule
